// File: rtl/stage_four.sv
// stage_four: write-back stage; holds the s3/s4 pipeline register and the REGS x WIDTH register file, commits results, serves two bypassed read ports plus r0_data, and exports the in-flight write-back (s4_wb_en/addr/data); halt_sys freezes all state
module stage_four #(
  parameter int REGS = 16,
  parameter int WIDTH = 16
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               halt_sys,
  input  logic [2*WIDTH-1:0] s3_data,
  input  logic [15:0]        s3_instruction,
  input  logic [1:0]         s3_wbc,
  input  logic [3:0]         rd1_addr,
  input  logic [3:0]         rd2_addr,
  output logic [WIDTH-1:0]   rd1_data,
  output logic [WIDTH-1:0]   rd2_data,
  output logic [WIDTH-1:0]   r0_data,
  output logic               s4_wb_en,
  output logic [3:0]         s4_wb_addr,
  output logic [2*WIDTH-1:0] s4_wb_data
);
  logic               wb_en_q, wb_en_d, wr32_q, wr32_d;
  logic [3:0]         wb_addr_q, wb_addr_d;
  logic [2*WIDTH-1:0] wb_data_q, wb_data_d;
  logic [WIDTH-1:0]   rf_q [REGS];
  logic [WIDTH-1:0]   rf_d [REGS];
  logic               unused_instr;
  assign unused_instr = ^{s3_instruction[15:12], s3_instruction[7:0]};
  function automatic logic [WIDTH-1:0] rd_byp(input logic [3:0] a);
    return (wr32_q && a == 4'd0) ? wb_data_q[2*WIDTH-1:WIDTH] :
           (wb_en_q && a == wb_addr_q) ? wb_data_q[WIDTH-1:0] : rf_q[a];
  endfunction
  always_comb begin
    wb_en_d   = halt_sys ? wb_en_q   : s3_wbc[0];
    wr32_d    = halt_sys ? wr32_q    : s3_wbc[1];
    wb_addr_d = halt_sys ? wb_addr_q : s3_instruction[11:8];
    wb_data_d = halt_sys ? wb_data_q : s3_data;
    rf_d = rf_q;
    if (!halt_sys && wb_en_q) rf_d[wb_addr_q] = wb_data_q[WIDTH-1:0];
    if (!halt_sys && wr32_q) rf_d[0] = wb_data_q[2*WIDTH-1:WIDTH];
    rd1_data = rd_byp(rd1_addr);
    rd2_data = rd_byp(rd2_addr);
    r0_data  = rd_byp(4'd0);
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      wb_en_q   <= 1'b0;
      wr32_q    <= 1'b0;
      wb_addr_q <= '0;
      wb_data_q <= '0;
      rf_q      <= '{default: '0};
    end else begin
      wb_en_q   <= wb_en_d;
      wr32_q    <= wr32_d;
      wb_addr_q <= wb_addr_d;
      wb_data_q <= wb_data_d;
      rf_q      <= rf_d;
    end
  end
  assign s4_wb_en   = wb_en_q;
  assign s4_wb_addr = wb_addr_q;
  assign s4_wb_data = wb_data_q;
endmodule

// File: tb/tb_stage_four.sv
// tb_stage_four: randomized and directed scoreboard bench for stage_four
module tb_stage_four;
  logic        clk, rst, halt_sys;
  logic [31:0] s3_data;
  logic [15:0] s3_instruction;
  logic [1:0]  s3_wbc;
  logic [3:0]  rd1_addr, rd2_addr;
  logic [15:0] rd1_data, rd2_data, r0_data;
  logic        s4_wb_en;
  logic [3:0]  s4_wb_addr;
  logic [31:0] s4_wb_data;

  stage_four dut (
    .clk(clk), .rst(rst), .halt_sys(halt_sys), .s3_data(s3_data),
    .s3_instruction(s3_instruction), .s3_wbc(s3_wbc),
    .rd1_addr(rd1_addr), .rd2_addr(rd2_addr),
    .rd1_data(rd1_data), .rd2_data(rd2_data), .r0_data(r0_data),
    .s4_wb_en(s4_wb_en), .s4_wb_addr(s4_wb_addr), .s4_wb_data(s4_wb_data)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct packed {
    logic [15:0] r1, r2, r0;
    logic        en;
    logic [3:0]  addr;
    logic [31:0] data;
  } exp_t;

  exp_t q[$];
  int checks = 0;
  int errors = 0;

  // Architectural model: committed register values plus the one pending write-back.
  logic [15:0] arch [16];
  logic        p_en, p_wr32;
  logic [3:0]  p_addr;
  logic [31:0] p_data;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, req, $time);
    end
  endtask

  task automatic cyc(input logic r, input logic h, input logic [31:0] d, input logic [3:0] rd,
                     input logic [1:0] wbc, input logic [3:0] a1, input logic [3:0] a2);
    logic [15:0] nxt [16];
    exp_t e;
    @(negedge clk);
    rst = r; halt_sys = h; s3_data = d; s3_wbc = wbc;
    rd1_addr = a1; rd2_addr = a2;
    s3_instruction = {4'($urandom), rd, 8'($urandom)};
    if (r) begin
      foreach (arch[i]) arch[i] = 16'h0;
      p_en = 1'b0; p_wr32 = 1'b0; p_addr = 4'h0; p_data = 32'h0;
    end else if (!h) begin
      if (p_en) arch[p_addr] = p_data[15:0];
      if (p_wr32) arch[0] = p_data[31:16];
      p_en = wbc[0]; p_wr32 = wbc[1]; p_addr = rd; p_data = d;
    end
    // Reads show the value each register will hold once the pending write-back lands.
    nxt = arch;
    if (p_en) nxt[p_addr] = p_data[15:0];
    if (p_wr32) nxt[0] = p_data[31:16];
    e.r1 = nxt[a1]; e.r2 = nxt[a2]; e.r0 = nxt[0];
    e.en = p_en; e.addr = p_addr; e.data = p_data;
    q.push_back(e);
  endtask

  task automatic idle(input logic [3:0] a1, input logic [3:0] a2);
    cyc(1'b0, 1'b0, 32'($urandom), 4'($urandom), 2'b00, a1, a2);
  endtask

  task automatic after_edge;
    @(posedge clk);
    #2;
  endtask

  initial begin : monitor
    exp_t e;
    forever begin
      @(posedge clk);
      #1;
      if (q.size() > 0) begin
        e = q.pop_front();
        chk("rd1_data", 32'(rd1_data), 32'(e.r1));
        chk("rd2_data", 32'(rd2_data), 32'(e.r2));
        chk("r0_data", 32'(r0_data), 32'(e.r0));
        chk("s4_wb_en", 32'(s4_wb_en), 32'(e.en));
        chk("s4_wb_addr", 32'(s4_wb_addr), 32'(e.addr));
        chk("s4_wb_data", s4_wb_data, e.data);
      end
    end
  end

  initial begin : stim
    rst = 1'b1; halt_sys = 1'b0; s3_data = '0; s3_instruction = '0; s3_wbc = '0;
    rd1_addr = '0; rd2_addr = '0;
    cyc(1'b1, 1'b0, 32'h0, 4'h0, 2'b00, 4'h0, 4'h0);
    cyc(1'b1, 1'b0, 32'h0, 4'h0, 2'b00, 4'h0, 4'h0);
    // Reset discards a pending write over a preloaded register.
    cyc(1'b0, 1'b0, 32'h0000_AAAA, 4'h5, 2'b01, 4'h5, 4'h5);
    idle(4'h5, 4'h0);
    after_edge();
    chk("preload_r5", 32'(rd1_data), 32'h0000_AAAA);
    cyc(1'b0, 1'b0, 32'h0000_5555, 4'h5, 2'b01, 4'h5, 4'h5);
    cyc(1'b1, 1'b1, 32'h0000_5555, 4'h5, 2'b11, 4'h5, 4'h3);
    after_edge();
    chk("reset_r5", 32'(rd1_data), 32'h0);
    chk("reset_r3", 32'(rd2_data), 32'h0);
    chk("reset_r0", 32'(r0_data), 32'h0);
    chk("reset_wb_en", 32'(s4_wb_en), 32'h0);
    // Basic write to R3.
    cyc(1'b0, 1'b0, 32'h0000_1234, 4'h3, 2'b01, 4'h3, 4'h0);
    after_edge();
    chk("basic_wb_en", 32'(s4_wb_en), 32'h1);
    chk("basic_wb_addr", 32'(s4_wb_addr), 32'h3);
    chk("basic_bypass", 32'(rd1_data), 32'h1234);
    idle(4'h3, 4'h3);
    after_edge();
    chk("basic_array", 32'(rd1_data), 32'h1234);
    // 32-bit write.
    cyc(1'b0, 1'b0, 32'hDEAD_BEEF, 4'h7, 2'b11, 4'h7, 4'h0);
    idle(4'h7, 4'h0);
    after_edge();
    chk("wr32_r7", 32'(rd1_data), 32'hBEEF);
    chk("wr32_r0_port", 32'(rd2_data), 32'hDEAD);
    chk("wr32_r0_data", 32'(r0_data), 32'hDEAD);
    // Conflict: upper half wins on R0.
    cyc(1'b0, 1'b0, 32'h1111_2222, 4'h0, 2'b11, 4'h0, 4'h0);
    after_edge();
    chk("conflict_bypass", 32'(rd1_data), 32'h1111);
    idle(4'h0, 4'h1);
    after_edge();
    chk("conflict_r0", 32'(r0_data), 32'h1111);
    // Halt with a pending write to R9.
    cyc(1'b0, 1'b0, 32'h0000_0042, 4'h9, 2'b01, 4'h9, 4'h9);
    for (int i = 0; i < 3; i++) begin
      cyc(1'b0, 1'b1, 32'($urandom), 4'h4, 2'b11, 4'h9, 4'h0);
      after_edge();
      chk("halt_bypass", 32'(rd1_data), 32'h0042);
      chk("halt_wb_addr", 32'(s4_wb_addr), 32'h9);
      chk("halt_wb_data", s4_wb_data, 32'h0000_0042);
    end
    cyc(1'b0, 1'b0, 32'h0000_7777, 4'h4, 2'b01, 4'h9, 4'h4);
    after_edge();
    chk("unhalt_r9", 32'(rd1_data), 32'h0042);
    chk("unhalt_wb_addr", 32'(s4_wb_addr), 32'h4);
    chk("unhalt_r4_bypass", 32'(rd2_data), 32'h7777);
    // Back-to-back writes to R2.
    cyc(1'b0, 1'b0, 32'h0000_0001, 4'h2, 2'b01, 4'h0, 4'h2);
    after_edge();
    chk("b2b_first", 32'(rd2_data), 32'h0001);
    cyc(1'b0, 1'b0, 32'h0000_0002, 4'h2, 2'b01, 4'h0, 4'h2);
    after_edge();
    chk("b2b_second", 32'(rd2_data), 32'h0002);
    idle(4'h0, 4'h2);
    after_edge();
    chk("b2b_final", 32'(rd2_data), 32'h0002);
    // Random traffic.
    for (int i = 0; i < 400; i++) begin
      cyc($urandom_range(0, 49) == 0, $urandom_range(0, 4) == 0, $urandom,
          ($urandom_range(0, 3) == 0) ? 4'h0 : 4'($urandom), 2'($urandom),
          4'($urandom), ($urandom_range(0, 3) == 0) ? 4'h0 : 4'($urandom));
    end
    for (int i = 0; i < 10 && q.size() > 0; i++) @(posedge clk);
    #3;
    if (q.size() > 0) begin
      errors++;
      $display("FAIL drain: %0d expected responses never checked", q.size());
    end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule

// File: doc/stage_four.md
Name: stage_four

Overview:
- Write-back stage of the 16-bit pipelined CPU. Sits directly downstream of the memory stage and consumes its 32-bit result word, s3_data.
- Holds the stage-3/4 pipeline register and the 16x16 register file, and commits results to the register file.
- Provides two combinational read ports to the decode stage, with same-cycle write bypass.
- Exports the in-flight write-back for the forwarding unit.

Parameters:
- REGS, 16, number of registers (address width 4).
- WIDTH, 16, register width in bits.

Ports:
- clk  input  1  system clock; all state updates on the rising edge.
- rst  input  1  synchronous reset, active-high.
- halt_sys  input  1  freezes the pipeline register and the register file when 1.
- s3_data  input  32  memory-stage result; [15:0] is the primary result, [31:16] is the upper product or remainder.
- s3_instruction  input  16  instruction; [11:8] is the destination register rd.
- s3_wbc  input  2  write-back control; [0] regwr, [1] wr32 (also write [31:16] to R0).
- rd1_addr  input  4  read port 1 address.
- rd2_addr  input  4  read port 2 address.
- rd1_data  output  16  read port 1 data.
- rd2_data  output  16  read port 2 data.
- r0_data  output  16  current R0 contents.
- s4_wb_en  output  1  registered regwr of the instruction in the write-back stage.
- s4_wb_addr  output  4  registered rd.
- s4_wb_data  output  32  registered s3_data.

Behaviour:
- Clocking and reset are fixed: one clock (clk); reset is synchronous and active-high (rst).
- Reset (rst=1 at an edge):
  - Pipeline register clears: s4_wb_en=0, s4_wb_addr=0, s4_wb_data=0, internal wr32=0.
  - All REGS registers clear to 0.
  - rst has priority over halt_sys and over any pending write.
  - A reset asserted mid-operation discards the in-flight write; no register is written on that edge.
- Pipeline register:
  - On each edge with rst=0 and halt_sys=0, it captures s3_data, s3_instruction[11:8], s3_wbc[0] and s3_wbc[1].
  - With halt_sys=1, it holds its value.
- Commit:
  - On each edge with rst=0 and halt_sys=0, the register file is updated from the pipeline register contents before that edge.
  - If wb_en=1: RF[wb_addr] <= wb_data[15:0].
  - If wr32=1: RF[0] <= wb_data[31:16].
  - Conflict: wb_en=1, wr32=1 and wb_addr=0 together. The wr32 write wins and RF[0] gets the upper half.
  - wr32=1 with wb_en=0 writes R0 only.
- Latency: values present on the s3_* inputs at edge N are latched at N and committed at edge N+1. They are readable from the array after N+1, and via bypass during the cycle between N and N+1.
- halt_sys=1: no commit and no latch. The register file and the pipeline register are unchanged. Outputs keep reflecting the frozen state.
- Read ports are combinational: rdX_data = RF[rdX_addr].
- Read bypass: when the pending commit would write the addressed register, rdX_data shows the pending value instead of the array value.
  - If wr32=1 and rdX_addr=0: rdX_data = wb_data[31:16].
  - Otherwise, if wb_en=1 and rdX_addr=wb_addr: rdX_data = wb_data[15:0].
  - Bypass stays active during halt_sys, because the pending value is still the architecturally next value.
  - r0_data uses the same bypass rule with address 0.
- Width rules:
  - No arithmetic in this block.
  - Writes are truncated exactly as specified; there is no sign extension.
  - Addresses are 4-bit; no out-of-range case exists.
- s4_wb_en, s4_wb_addr and s4_wb_data are the raw pipeline-register outputs, valid one cycle after capture.

Test Plan:
- Reset: preload RF[5]=16'hAAAA, then pulse rst for one edge while an s3 write to R5 is pending. Required: every read port returns 0, s4_wb_en=0, R5=0.
- Basic write: s3_data=32'h0000_1234, rd=3, wbc=2'b01. Required:
  - Edge 1: s4_wb_en=1, s4_wb_addr=3.
  - Between edges 1 and 2: rd1_addr=3 gives 16'h1234 via bypass.
  - After edge 2: 16'h1234 from the array.
  - R3 was 0 before edge 2.
- 32-bit write: s3_data=32'hDEAD_BEEF, rd=7, wbc=2'b11. Required: after commit, R7=16'hBEEF, R0=16'hDEAD, r0_data=16'hDEAD.
- Conflict: s3_data=32'h1111_2222, rd=0, wbc=2'b11. Required: R0=16'h1111.
- Halt:
  - Latch a write to R9=16'h0042, then raise halt_sys for 3 edges while changing the s3 inputs.
  - Required during halt: R9 array value is unchanged, rd1 at address 9 reads 16'h0042 via bypass, s4_wb_* are frozen.
  - After deassert, the R9 commit occurs on the next edge and the new s3 inputs are latched.
- Back-to-back: writes to R2 (16'h0001) then R2 (16'h0002) on consecutive cycles. Required: rd2_addr=2 reads 16'h0001 then 16'h0002; the final array value of R2 is 16'h0002.
